// File: rtl/rgb_fpga_pkg.sv
// Shared constants and the FSM state type for the HUB75 per-line output stage.
package rgb_fpga_pkg;

   localparam int MATRIX_ROWS = 16;
   localparam int ADDR_W      = 4;
   localparam int RGB_W       = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOW,
      S_HIGH,
      S_BLANK,
      S_LATCH,
      S_SHOW,
      S_DONE
   } state_e;

endpackage

// File: rtl/rgb_fpga_line_driver_if.sv
// Control, frame-buffer read and panel signals of the line driver, plus the FSM state for observation.
interface rgb_fpga_line_driver_if #(
   parameter int COLS = 32
);
   import rgb_fpga_pkg::*;

   localparam int RD_W = ADDR_W + $clog2(COLS);

   // line_start: one-cycle request, taken only in IDLE and never queued.
   // line_rdy: one-cycle completion pulse. rd_data is sampled at the edge that
   // ends the cycle in which rd_addr holds the new address; no backpressure.
   logic              enable;
   logic              line_start;
   logic [ADDR_W-1:0] matrix_addr;
   logic [RD_W-1:0]   rd_addr;
   logic [RGB_W-1:0]  rd_data;
   logic              line_rdy;
   logic              hub_clk;
   logic              hub_lat;
   logic              hub_oe_n;
   logic [RGB_W-1:0]  hub_rgb;
   logic [ADDR_W-1:0] hub_addr;
   state_e            state;

   modport master (
      output enable, line_start, matrix_addr, rd_data,
      input  rd_addr, line_rdy, hub_clk, hub_lat, hub_oe_n, hub_rgb, hub_addr, state
   );

   modport slave (
      input  enable, line_start, matrix_addr, rd_data,
      output rd_addr, line_rdy, hub_clk, hub_lat, hub_oe_n, hub_rgb, hub_addr, state
   );

endinterface

// File: rtl/rgb_fpga_phase_timer.sv
// Loadable down counter with a zero flag; times both the shift-clock phases and the lit window.
module rgb_fpga_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rgb_fpga_line_driver.sv
// HUB75 per-line output stage: fetch and shift one line of pixel pairs, latch, then light the row.
module rgb_fpga_line_driver
   import rgb_fpga_pkg::*;
#(
   parameter int COLS      = 32,
   parameter int CLK_DIV   = 2,
   parameter int OE_CYCLES = 64
) (
   input logic                   clk,
   input logic                   rst,
   rgb_fpga_line_driver_if.slave bus
);

   localparam int CW   = $clog2(COLS);
   localparam int TMAX = (CLK_DIV > OE_CYCLES) ? CLK_DIV : OE_CYCLES;
   localparam int TW   = $clog2(TMAX) + 1;

   state_e            state_q;
   logic [ADDR_W-1:0] row_q;
   logic [CW-1:0]     col_q;
   logic [ADDR_W+CW-1:0] rd_addr_q;
   logic [RGB_W-1:0]  hub_rgb_q;
   logic              hub_clk_q;
   logic              hub_lat_q;
   logic              hub_oe_n_q;
   logic [ADDR_W-1:0] hub_addr_q;
   logic              line_rdy_q;

   logic              tmr_load_d;
   logic [TW-1:0]     tmr_val_d;
   logic              tmr_zero;

   // The timer is loaded on the same edge that enters a timed state, so the
   // first cycle of that state already sees the full count.
   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = TW'(CLK_DIV - 1);
      case (state_q)
         S_FETCH: tmr_load_d = 1'b1;
         S_LOW:   tmr_load_d = tmr_zero;
         S_LATCH: begin
            tmr_load_d = 1'b1;
            tmr_val_d  = TW'(OE_CYCLES - 1);
         end
         default: ;
      endcase
   end

   rgb_fpga_phase_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_d),
      .load_val_i (tmr_val_d),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         rd_addr_q  <= '0;
         hub_rgb_q  <= '0;
         hub_clk_q  <= 1'b0;
         hub_lat_q  <= 1'b0;
         hub_oe_n_q <= 1'b1;
         hub_addr_q <= '0;
         line_rdy_q <= 1'b0;
      end else if (!bus.enable && state_q != S_IDLE) begin
         // Abort: everything back to idle values, but the panel keeps its row address.
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         rd_addr_q  <= '0;
         hub_rgb_q  <= '0;
         hub_clk_q  <= 1'b0;
         hub_lat_q  <= 1'b0;
         hub_oe_n_q <= 1'b1;
         line_rdy_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.enable && bus.line_start) begin
                  row_q     <= bus.matrix_addr;
                  col_q     <= '0;
                  rd_addr_q <= {bus.matrix_addr, {CW{1'b0}}};
                  state_q   <= S_FETCH;
               end
            end
            S_FETCH: begin
               hub_rgb_q <= bus.rd_data;
               hub_clk_q <= 1'b0;
               state_q   <= S_LOW;
            end
            S_LOW: begin
               if (tmr_zero) begin
                  hub_clk_q <= 1'b1;
                  state_q   <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (tmr_zero) begin
                  hub_clk_q <= 1'b0;
                  if (col_q == CW'(COLS - 1)) begin
                     hub_oe_n_q <= 1'b1;
                     state_q    <= S_BLANK;
                  end else begin
                     col_q     <= col_q + CW'(1);
                     rd_addr_q <= {row_q, col_q + CW'(1)};
                     state_q   <= S_FETCH;
                  end
               end
            end
            S_BLANK: begin
               hub_lat_q  <= 1'b1;
               hub_addr_q <= row_q;
               state_q    <= S_LATCH;
            end
            S_LATCH: begin
               hub_lat_q  <= 1'b0;
               hub_oe_n_q <= 1'b0;
               state_q    <= S_SHOW;
            end
            S_SHOW: begin
               if (tmr_zero) begin
                  hub_oe_n_q <= 1'b1;
                  line_rdy_q <= 1'b1;
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               line_rdy_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.rd_addr  = rd_addr_q;
   assign bus.hub_rgb  = hub_rgb_q;
   assign bus.hub_clk  = hub_clk_q;
   assign bus.hub_lat  = hub_lat_q;
   assign bus.hub_oe_n = hub_oe_n_q;
   assign bus.hub_addr = hub_addr_q;
   assign bus.line_rdy = line_rdy_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_rgb_fpga_line_driver.sv
// Bench for the line driver: a short configuration (4 cols, CLK_DIV 1, OE 3) and the default one.
module tb_rgb_fpga_line_driver;
   import rgb_fpga_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rgb_fpga_line_driver_if #(.COLS(4))  s_bus ();
   rgb_fpga_line_driver_if #(.COLS(32)) d_bus ();

   rgb_fpga_line_driver #(.COLS(4), .CLK_DIV(1), .OE_CYCLES(3)) u_short (
      .clk (clk),
      .rst (rst),
      .bus (s_bus)
   );

   rgb_fpga_line_driver #(.COLS(32), .CLK_DIV(2), .OE_CYCLES(64)) u_dflt (
      .clk (clk),
      .rst (rst),
      .bus (d_bus)
   );

   logic [5:0] mem_d [512];
   assign s_bus.rd_data = 6'(s_bus.rd_addr[1:0]) + 6'd1;
   assign d_bus.rd_data = mem_d[d_bus.rd_addr];

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] exp_s_q[$];
   logic [15:0] exp_d_q[$];

   int s_rise = 0, s_lat = 0, s_oe = 0, s_rdy = 0, s_viol = 0, s_hi = 0;
   int d_rise = 0, d_lat = 0, d_oe = 0, d_rdy = 0, d_viol = 0, d_hi = 0;
   logic s_pclk = 1'b0, s_plat = 1'b0, d_pclk = 1'b0, d_plat = 1'b0;
   logic [3:0] s_row_exp = '0, d_row_exp = '0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitors sample on the falling edge, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (s_bus.hub_clk && !s_pclk) begin
         s_rise++;
         if (exp_s_q.size() == 0) check_vec("s_sb_empty", 32'(exp_s_q.size()), 32'd1);
         else check_vec("s_shift", 32'({s_bus.rd_addr, s_bus.hub_rgb}), 32'(exp_s_q.pop_front()));
      end
      if (!s_bus.hub_clk && s_pclk) check_vec("s_clk_high", 32'(s_hi), 32'd1);
      s_hi = s_bus.hub_clk ? s_hi + 1 : 0;
      if (s_bus.hub_lat && !s_plat) s_lat++;
      if (!s_bus.hub_oe_n) begin
         s_oe++;
         check_vec("s_addr_lit", 32'(s_bus.hub_addr), 32'(s_row_exp));
      end
      if (!s_bus.hub_oe_n && (s_bus.hub_lat || s_bus.hub_clk)) s_viol++;
      if (s_bus.line_rdy) s_rdy++;
      s_pclk = s_bus.hub_clk;
      s_plat = s_bus.hub_lat;
   end

   initial forever begin
      @(negedge clk);
      if (d_bus.hub_clk && !d_pclk) begin
         d_rise++;
         if (exp_d_q.size() == 0) check_vec("d_sb_empty", 32'(exp_d_q.size()), 32'd1);
         else check_vec("d_shift", 32'({d_bus.rd_addr, d_bus.hub_rgb}), 32'(exp_d_q.pop_front()));
      end
      if (!d_bus.hub_clk && d_pclk) check_vec("d_clk_high", 32'(d_hi), 32'd2);
      d_hi = d_bus.hub_clk ? d_hi + 1 : 0;
      if (d_bus.hub_lat && !d_plat) d_lat++;
      if (!d_bus.hub_oe_n) begin
         d_oe++;
         check_vec("d_addr_lit", 32'(d_bus.hub_addr), 32'(d_row_exp));
      end
      if (!d_bus.hub_oe_n && (d_bus.hub_lat || d_bus.hub_clk)) d_viol++;
      if (d_bus.line_rdy) d_rdy++;
      d_pclk = d_bus.hub_clk;
      d_plat = d_bus.hub_lat;
   end

   // Caller is in the cycle whose ending edge (E0) should take the request.
   task automatic start_s(input logic [3:0] row);
      for (int c = 0; c < 4; c++) exp_s_q.push_back(16'({row, 2'(c), 6'(c + 1)}));
      s_row_exp = row;
      s_bus.matrix_addr = row;
      s_bus.line_start = 1'b1;
      @(posedge clk);
      #1 s_bus.line_start = 1'b0;
   endtask

   task automatic start_d(input logic [3:0] row);
      for (int c = 0; c < 32; c++) exp_d_q.push_back(16'({row, 5'(c), mem_d[{row, 5'(c)}]}));
      d_row_exp = row;
      d_bus.matrix_addr = row;
      d_bus.line_start = 1'b1;
      @(posedge clk);
      #1 d_bus.line_start = 1'b0;
   endtask

   // Edges after E0 until line_rdy is seen; 0 if it never arrives.
   task automatic wait_rdy(input bit dflt, output int lat);
      lat = 0;
      for (int k = 1; k <= 600 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (dflt ? d_bus.line_rdy : s_bus.line_rdy) lat = k;
      end
   endtask

   task automatic wait_s(input state_e st, input int col);
      bit hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk);
         #1;
         hit = (s_bus.state == st) && (col < 0 || int'(s_bus.rd_addr[1:0]) == col);
      end
      if (!hit) check_vec("s_wait_timeout", 32'(s_bus.state), 32'(st));
   endtask

   int lat;
   int b_rise, b_lat, b_oe, b_rdy;

   initial begin
      for (int i = 0; i < 512; i++) mem_d[i] = 6'($urandom_range(0, 63));
      s_bus.enable = 1'b1; s_bus.line_start = 1'b0; s_bus.matrix_addr = '0;
      d_bus.enable = 1'b1; d_bus.line_start = 1'b0; d_bus.matrix_addr = '0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_vec("rst_oe_n",    32'(s_bus.hub_oe_n), 32'd1);
      check_vec("rst_hub_clk", 32'(s_bus.hub_clk),  32'd0);
      check_vec("rst_hub_lat", 32'(s_bus.hub_lat),  32'd0);
      check_vec("rst_hub_rgb", 32'(s_bus.hub_rgb),  32'd0);
      check_vec("rst_hub_adr", 32'(s_bus.hub_addr), 32'd0);
      check_vec("rst_rd_addr", 32'(s_bus.rd_addr),  32'd0);
      check_vec("rst_rdy",     32'(s_bus.line_rdy), 32'd0);
      check_vec("rst_state",   32'(s_bus.state),    32'(S_IDLE));
      check_vec("rst_d_oe_n",  32'(d_bus.hub_oe_n), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Short line, row 5
      b_rise = s_rise; b_lat = s_lat; b_oe = s_oe; b_rdy = s_rdy;
      start_s(4'd5);
      wait_rdy(1'b0, lat);
      check_vec("short_latency", 32'(lat), 32'd17);
      repeat (3) @(posedge clk);
      #1;
      check_vec("short_rises",  32'(s_rise - b_rise), 32'd4);
      check_vec("short_lat",    32'(s_lat - b_lat),   32'd1);
      check_vec("short_oe_cyc", 32'(s_oe - b_oe),     32'd3);
      check_vec("short_rdy",    32'(s_rdy - b_rdy),   32'd1);
      check_vec("short_addr",   32'(s_bus.hub_addr),  32'd5);
      check_vec("short_sb",     32'(exp_s_q.size()),  32'd0);

      // Start request with row 3 while row 5 is shifting
      b_rdy = s_rdy;
      start_s(4'd5);
      wait_s(S_LOW, 1);
      s_bus.matrix_addr = 4'd3;
      s_bus.line_start = 1'b1;
      @(posedge clk);
      #1 s_bus.line_start = 1'b0;
      wait_rdy(1'b0, lat);
      check_vec("ign_addr", 32'(s_bus.hub_addr), 32'd5);
      repeat (40) @(posedge clk);
      #1;
      check_vec("ign_rdy",   32'(s_rdy - b_rdy),   32'd1);
      check_vec("ign_state", 32'(s_bus.state),     32'(S_IDLE));
      check_vec("ign_sb",    32'(exp_s_q.size()),  32'd0);

      // Abort during SHOW
      b_rdy = s_rdy;
      start_s(4'd2);
      wait_s(S_SHOW, -1);
      s_bus.enable = 1'b0;
      @(posedge clk);
      #1;
      check_vec("abort_oe_n",  32'(s_bus.hub_oe_n), 32'd1);
      check_vec("abort_state", 32'(s_bus.state),    32'(S_IDLE));
      check_vec("abort_rdaddr", 32'(s_bus.rd_addr), 32'd0);
      check_vec("abort_hubadr", 32'(s_bus.hub_addr), 32'd2);
      s_bus.enable = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_vec("abort_no_rdy", 32'(s_rdy - b_rdy), 32'd0);
      check_vec("abort_state2", 32'(s_bus.state),   32'(S_IDLE));

      // Reset during HIGH of column 1
      start_s(4'd6);
      wait_s(S_HIGH, 1);
      #1 rst = 1'b1;
      #1;
      check_vec("midrst_oe_n",  32'(s_bus.hub_oe_n), 32'd1);
      check_vec("midrst_clk",   32'(s_bus.hub_clk),  32'd0);
      check_vec("midrst_rdadr", 32'(s_bus.rd_addr),  32'd0);
      check_vec("midrst_rgb",   32'(s_bus.hub_rgb),  32'd0);
      check_vec("midrst_state", 32'(s_bus.state),    32'(S_IDLE));
      exp_s_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      b_rise = s_rise;
      start_s(4'd6);
      wait_rdy(1'b0, lat);
      check_vec("midrst_latency", 32'(lat), 32'd17);
      repeat (2) @(posedge clk);
      #1;
      check_vec("midrst_rises", 32'(s_rise - b_rise), 32'd4);
      check_vec("midrst_sb",    32'(exp_s_q.size()),  32'd0);

      // Back-to-back lines
      start_s(4'd1);
      wait_rdy(1'b0, lat);
      check_vec("b2b_lat1", 32'(lat), 32'd17);
      @(posedge clk);
      #1;
      start_s(4'd4);
      wait_rdy(1'b0, lat);
      check_vec("b2b_lat2", 32'(lat), 32'd17);
      repeat (3) @(posedge clk);
      #1;
      check_vec("b2b_addr",    32'(s_bus.hub_addr), 32'd4);
      check_vec("b2b_sb",      32'(exp_s_q.size()), 32'd0);
      check_vec("s_oe_overlap", 32'(s_viol),        32'd0);

      // Default configuration, row 15
      b_rise = d_rise; b_lat = d_lat; b_oe = d_oe;
      start_d(4'd15);
      wait_rdy(1'b1, lat);
      check_vec("dflt_latency", 32'(lat), 32'd226);
      repeat (3) @(posedge clk);
      #1;
      check_vec("dflt_rises",   32'(d_rise - b_rise), 32'd32);
      check_vec("dflt_lat",     32'(d_lat - b_lat),   32'd1);
      check_vec("dflt_oe_cyc",  32'(d_oe - b_oe),     32'd64);
      check_vec("dflt_addr",    32'(d_bus.hub_addr),  32'd15);
      check_vec("dflt_sb",      32'(exp_d_q.size()),  32'd0);
      check_vec("d_oe_overlap", 32'(d_viol),          32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
